band_gain_mixer: RTL and testbench



---
 rtl/band_gain_mixer.sv | 144 ++++++++++++++
 tb/tb_band_gain_mixer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_gain_mixer.sv
// band_gain_mixer: snapshots NUM_BANDS band samples and gains, then runs a serial multiply-accumulate.
// The sum is rounded half-up, saturated to DATA_W bits and emitted as one mix per strobe. Rev 1.0
`default_nettype none

module band_gain_mixer #(
   parameter int NUM_BANDS = 8,
   parameter int DATA_W    = 16,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 5
) (
   input  logic                          clk,
   input  logic                          clk_enable,
   input  logic                          rst,
   input  logic                          sample_valid,
   input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
   input  logic [NUM_BANDS*GAIN_W-1:0]   band_gain,
   output logic signed [DATA_W-1:0]      mix_out,
   output logic                          mix_valid,
   output logic                          busy,
   output logic                          clip,
   output logic                          overrun
);

   localparam int IDX_W  = $clog2(NUM_BANDS);
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int ACC_W  = PROD_W + IDX_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t state, state_next;

   logic [NUM_BANDS*DATA_W-1:0] band_q;
   logic [NUM_BANDS*GAIN_W-1:0] gain_q;
   logic signed [ACC_W-1:0]     acc;
   logic [IDX_W-1:0]            idx;

   logic                        start;
   logic                        last_band;
   logic signed [DATA_W-1:0]    band_sel;
   logic [GAIN_W-1:0]           gain_sel;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_W-1:0]     rounded;
   logic signed [ACC_W-1:0]     shifted;
   logic signed [DATA_W-1:0]    sat_val;
   logic                        sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (clk_enable) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      busy       = (state != IDLE);
      last_band  = (idx == IDX_W'(NUM_BANDS - 1));
      case (state)
         IDLE: begin
            if (sample_valid) begin
               start      = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (last_band) begin
               state_next = OUTPUT;
            end
         end
         OUTPUT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Gain is zero-extended so the multiply stays signed without reinterpreting gains >= 128.
   assign band_sel = band_q[idx*DATA_W +: DATA_W];
   assign gain_sel = gain_q[idx*GAIN_W +: GAIN_W];
   assign prod     = band_sel * $signed({1'b0, gain_sel});
   assign rounded  = acc + ACC_W'(1 << (GAIN_FRAC - 1));
   assign shifted  = rounded >>> GAIN_FRAC;

   always_comb begin
      sat     = 1'b0;
      sat_val = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX) begin
         sat     = 1'b1;
         sat_val = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         sat     = 1'b1;
         sat_val = SAT_MIN[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         band_q    <= '0;
         gain_q    <= '0;
         acc       <= '0;
         idx       <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         clip      <= 1'b0;
         overrun   <= 1'b0;
      end else if (clk_enable) begin
         mix_valid <= 1'b0;
         if (sample_valid && busy) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  band_q <= band_in;
                  gain_q <= band_gain;
                  acc    <= '0;
                  idx    <= '0;
               end
            end
            ACCUM: begin
               acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
               idx <= idx + 1'b1;
            end
            OUTPUT: begin
               mix_out   <= sat_val;
               mix_valid <= 1'b1;
               if (sat) begin
                  clip <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_band_gain_mixer.sv
// tb_band_gain_mixer: directed and randomized scenarios against an arithmetic reference of the mix.
// Rev 1.0
`default_nettype none

module tb_band_gain_mixer;

   localparam int NB = 8;
   localparam int DW = 16;
   localparam int GW = 8;

   logic                   clk;
   logic                   clk_enable;
   logic                   rst;
   logic                   sample_valid;
   logic [NB*DW-1:0]       band_in;
   logic [NB*GW-1:0]       band_gain;
   logic signed [DW-1:0]   mix_out;
   logic                   mix_valid;
   logic                   busy;
   logic                   clip;
   logic                   overrun;

   int checks = 0;
   int errors = 0;

   logic signed [DW-1:0] b [NB];
   logic [GW-1:0]        g [NB];
   bit exp_clip    = 0;
   bit exp_overrun = 0;

   band_gain_mixer #(.NUM_BANDS(NB), .DATA_W(DW), .GAIN_W(GW), .GAIN_FRAC(5)) dut (
      .clk(clk), .clk_enable(clk_enable), .rst(rst), .sample_valid(sample_valid),
      .band_in(band_in), .band_gain(band_gain), .mix_out(mix_out),
      .mix_valid(mix_valid), .busy(busy), .clip(clip), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pack();
      for (int k = 0; k < NB; k++) begin
         band_in[k*DW +: DW]   = b[k];
         band_gain[k*GW +: GW] = g[k];
      end
   endtask

   task automatic set_all(input int bv, input int gv);
      for (int k = 0; k < NB; k++) begin
         b[k] = DW'(bv);
         g[k] = GW'(gv);
      end
      pack();
   endtask

   // Weighted sum in Q.5, floor((sum + 16) / 32), then clamp to 16-bit signed.
   function automatic logic signed [DW-1:0] ref_mix(output bit sat);
      longint s = 0;
      longint r;
      for (int k = 0; k < NB; k++) s += longint'(b[k]) * longint'({1'b0, g[k]});
      s = s + 16;
      r = (s >= 0) ? s / 32 : -((-s + 31) / 32);
      sat = 0;
      if (r > 32767) begin r = 32767; sat = 1; end
      if (r < -32768) begin r = -32768; sat = 1; end
      return DW'(r);
   endfunction

   task automatic drive_mix(input int inject_at, input logic signed [DW-1:0] inj_val,
                            input int stall_at, input int stall_len,
                            output int lat, output int pulses, output logic signed [DW-1:0] out_val);
      lat = -1;
      pulses = 0;
      out_val = 'x;
      sample_valid = 1'b1;
      tick();
      for (int t = 1; t <= 30; t++) begin
         sample_valid = (t == inject_at);
         if (t == inject_at) begin
            for (int k = 0; k < NB; k++) band_in[k*DW +: DW] = inj_val;
         end
         clk_enable = !(stall_at >= 0 && t > stall_at && t <= stall_at + stall_len);
         tick();
         if (clk_enable && mix_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = t;
               out_val = mix_out;
            end
         end
      end
      sample_valid = 1'b0;
      clk_enable = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({mix_out, mix_valid, busy, clip, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_state: got out=%0d v=%b busy=%b clip=%b ovr=%b, want all 0",
                  mix_out, mix_valid, busy, clip, overrun);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_unity();
      int lat, pulses;
      logic signed [DW-1:0] out;
      set_all(1000, 32);
      drive_mix(-1, 0, -1, 0, lat, pulses, out);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL unity_latency: got %0d want 9", lat); end
      checks++;
      if (out !== 16'sd8000) begin errors++; $display("FAIL unity_value: got %0d want 8000", out); end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL unity_pulses: got %0d want 1", pulses); end
      checks++;
      if (clip !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL unity_flags: got clip=%b busy=%b want 0 0", clip, busy);
      end
      checks++;
      if (mix_out !== 16'sd8000) begin errors++; $display("FAIL unity_hold: got %0d want 8000", mix_out); end
   endtask

   task automatic test_saturation();
      int lat, pulses;
      bit sat;
      logic signed [DW-1:0] out;
      logic signed [DW-1:0] exp_tab [6] = '{16'sd32767, 16'sd0, -16'sd32768, 16'sd1, 16'sd0, -16'sd1};
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: set_all(32767, 255);
            1: set_all(0, 255);
            2: set_all(-32768, 255);
            3: begin set_all(0, 0); b[0] = 16'sd1;  g[0] = 8'd16; pack(); end
            4: begin set_all(0, 0); b[0] = -16'sd1; g[0] = 8'd16; pack(); end
            default: begin set_all(0, 0); b[0] = -16'sd3; g[0] = 8'd16; pack(); end
         endcase
         void'(ref_mix(sat));
         exp_clip = exp_clip | sat;
         drive_mix(-1, 0, -1, 0, lat, pulses, out);
         checks++;
         if (out !== exp_tab[i] || lat !== 9) begin
            errors++;
            $display("FAIL sat_round_%0d: got out=%0d lat=%0d want out=%0d lat=9", i, out, lat, exp_tab[i]);
         end
         checks++;
         if (clip !== exp_clip) begin
            errors++; $display("FAIL sat_clip_%0d: got %b want %b", i, clip, exp_clip);
         end
      end
   endtask

   task automatic test_snapshot_overrun();
      int lat, pulses;
      logic signed [DW-1:0] out;
      set_all(0, 0);
      b[3] = 16'sd2000;
      g[3] = 8'd64;
      pack();
      drive_mix(2, 16'sd5000, -1, 0, lat, pulses, out);
      exp_overrun = 1;
      checks++;
      if (out !== 16'sd4000) begin errors++; $display("FAIL snapshot_value: got %0d want 4000", out); end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL snapshot_pulses: got %0d want 1", pulses); end
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
   endtask

   task automatic test_stall();
      int lat, pulses;
      logic signed [DW-1:0] out;
      set_all(1000, 32);
      drive_mix(-1, 0, 3, 3, lat, pulses, out);
      checks++;
      if (lat !== 12 || out !== 16'sd8000 || pulses !== 1) begin
         errors++;
         $display("FAIL stall: got lat=%0d out=%0d pulses=%0d want 12 8000 1", lat, out, pulses);
      end
   endtask

   task automatic test_reset_mid();
      int lat, pulses;
      bit sat;
      logic signed [DW-1:0] out, exp;
      set_all(1000, 32);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midmix_busy: got %b want 1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_clip = 0;
      exp_overrun = 0;
      checks++;
      if ({mix_out, mix_valid, busy, clip, overrun} !== '0) begin
         errors++;
         $display("FAIL midmix_reset: got out=%0d v=%b busy=%b clip=%b ovr=%b, want all 0",
                  mix_out, mix_valid, busy, clip, overrun);
      end
      pulses = 0;
      repeat (15) begin
         tick();
         if (mix_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL midmix_no_pulse: got %0d pulses want 0", pulses); end
      for (int k = 0; k < NB; k++) begin
         b[k] = DW'($urandom_range(0, 4000)) - 16'sd2000;
         g[k] = GW'($urandom_range(0, 48));
      end
      pack();
      exp = ref_mix(sat);
      exp_clip = exp_clip | sat;
      drive_mix(-1, 0, -1, 0, lat, pulses, out);
      checks++;
      if (out !== exp || lat !== 9 || clip !== exp_clip) begin
         errors++;
         $display("FAIL post_reset_mix: got out=%0d lat=%0d clip=%b want %0d 9 %b", out, lat, clip, exp, exp_clip);
      end
   endtask

   task automatic test_random();
      int lat, pulses, inj, st_at, st_len;
      bit sat;
      logic signed [DW-1:0] out, exp;
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < NB; k++) begin
            if (i[0]) begin
               b[k] = DW'($urandom);
               g[k] = GW'($urandom);
            end else begin
               b[k] = DW'($urandom_range(0, 8000)) - 16'sd4000;
               g[k] = GW'($urandom_range(0, 64));
            end
         end
         pack();
         inj    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
         st_at  = int'($urandom_range(1, 8));
         st_len = int'($urandom_range(0, 3));
         exp = ref_mix(sat);
         exp_clip = exp_clip | sat;
         if (inj > 0 && !(inj > st_at && inj <= st_at + st_len)) exp_overrun = 1;
         drive_mix(inj, DW'($urandom), st_at, st_len, lat, pulses, out);
         checks++;
         if (out !== exp || lat !== 9 + st_len || pulses !== 1) begin
            errors++;
            $display("FAIL random_%0d: got out=%0d lat=%0d pulses=%0d want %0d %0d 1",
                     i, out, lat, pulses, exp, 9 + st_len);
         end
         checks++;
         if (clip !== exp_clip || overrun !== exp_overrun) begin
            errors++;
            $display("FAIL random_flags_%0d: got clip=%b ovr=%b want %b %b", i, clip, overrun, exp_clip, exp_overrun);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      clk_enable = 1'b1;
      sample_valid = 1'b0;
      band_in = '0;
      band_gain = '0;
      test_reset();
      test_unity();
      test_saturation();
      test_snapshot_overrun();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
